// File: rtl/dma_pkg.sv
// Shared definitions for the DMA address/count unit.
//   REG_*       : CPU register offsets with special meaning
//   NUM_CH      : channel count (fixed at 4)
//   ch_state_t  : the four 16-bit registers owned by one channel
package dma_pkg;

  localparam int NUM_CH = 4;

  localparam logic [3:0] REG_STATUS = 4'd8;
  localparam logic [3:0] REG_CLR_FF = 4'd12;
  localparam logic [3:0] REG_MCLR   = 4'd13;

  typedef struct packed {
    logic [15:0] base_addr;
    logic [15:0] cur_addr;
    logic [15:0] base_cnt;
    logic [15:0] cur_cnt;
  } ch_state_t;

endpackage

// File: rtl/dma_channel_regs.sv
// Address/count registers for one DMA channel.
//   clk, rst      : clock, async active-high reset
//   clr           : synchronous master clear
//   step          : a transfer completed on this channel
//   dec, autoinit : mode bits for this channel
//   wr_addr/cnt   : CPU byte write to the address / count pair
//   wr_hi         : selects the high byte for the write
//   wr_data       : CPU write byte
//   st            : current register contents
//   tc_hit        : combinational; this step consumes the final count
module dma_channel_regs
  import dma_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       step,
  input  logic       dec,
  input  logic       autoinit,
  input  logic       wr_addr,
  input  logic       wr_cnt,
  input  logic       wr_hi,
  input  logic [7:0] wr_data,
  output ch_state_t  st,
  output logic       tc_hit
);

  logic [15:0] step_addr;

  // A count of zero still means one transfer remains.
  assign tc_hit    = step && (st.cur_cnt == 16'h0000);
  assign step_addr = dec ? st.cur_addr - 16'd1 : st.cur_addr + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= '0;
    end else if (clr) begin
      st <= '0;
    end else begin
      // A CPU write to a register pair wins over the step's update to it.
      if (wr_addr) begin
        if (wr_hi) begin
          st.base_addr[15:8] <= wr_data;
          st.cur_addr[15:8]  <= wr_data;
        end else begin
          st.base_addr[7:0]  <= wr_data;
          st.cur_addr[7:0]   <= wr_data;
        end
      end else if (step) begin
        st.cur_addr <= (tc_hit && autoinit) ? st.base_addr : step_addr;
      end

      if (wr_cnt) begin
        if (wr_hi) begin
          st.base_cnt[15:8] <= wr_data;
          st.cur_cnt[15:8]  <= wr_data;
        end else begin
          st.base_cnt[7:0]  <= wr_data;
          st.cur_cnt[7:0]   <= wr_data;
        end
      end else if (step) begin
        // Without autoinit the count simply wraps 0 -> FFFF.
        st.cur_cnt <= (tc_hit && autoinit) ? st.base_cnt : st.cur_cnt - 16'd1;
      end
    end
  end

endmodule

// File: rtl/dma_addr_count_unit.sv
// Per-channel address and word-count engine for a 4-channel DMA controller.
//   clk, rst   : clock, async active-high reset
//   wr_stb     : CPU register write strobe
//   rd_stb     : CPU register read strobe
//   reg_addr   : CPU register offset
//   db_in      : CPU write data
//   db_out     : CPU read data, valid the cycle after rd_stb
//   active_ch  : channel granted by the control FSM
//   xfer_step  : one pulse per completed transfer on active_ch
//   autoinit   : per-channel auto-initialise enable
//   addr_dec   : per-channel address-decrement select
//   mem_addr   : current address of active_ch (one cycle latency)
//   tc         : pulse when a step consumes the final count
//   tc_status  : sticky per-channel TC flags, cleared by a status read
//   mark       : pulse every MARK_PERIOD steps on the same channel
module dma_addr_count_unit
  import dma_pkg::*;
#(
  parameter int MARK_PERIOD = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_stb,
  input  logic              rd_stb,
  input  logic [3:0]        reg_addr,
  input  logic [7:0]        db_in,
  output logic [7:0]        db_out,
  input  logic [1:0]        active_ch,
  input  logic              xfer_step,
  input  logic [NUM_CH-1:0] autoinit,
  input  logic [NUM_CH-1:0] addr_dec,
  output logic [15:0]       mem_addr,
  output logic              tc,
  output logic [NUM_CH-1:0] tc_status,
  output logic              mark
);

  localparam logic [15:0] MARK_MASK = 16'(MARK_PERIOD - 1);

  ch_state_t         st [NUM_CH];
  logic [NUM_CH-1:0] tc_hit;

  logic        byte_ptr;
  logic [1:0]  last_ch;
  logic [15:0] step_cnt;
  logic [15:0] step_cnt_nxt;
  logic [7:0]  rd_data;
  logic [15:0] rd_word;

  logic ch_reg, wr_ch, rd_eff, rd_status, mclr, ptr_clr, ptr_tog;

  assign ch_reg    = !reg_addr[3];
  assign wr_ch     = wr_stb && ch_reg;
  // A write in the same cycle suppresses the read entirely.
  assign rd_eff    = rd_stb && !wr_stb;
  assign rd_status = rd_eff && (reg_addr == REG_STATUS);
  assign mclr      = wr_stb && (reg_addr == REG_MCLR);
  assign ptr_clr   = wr_stb && (reg_addr == REG_CLR_FF);
  assign ptr_tog   = (wr_stb || rd_stb) && ch_reg;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dma_channel_regs u_regs (
      .clk      (clk),
      .rst      (rst),
      .clr      (mclr),
      .step     (xfer_step && (active_ch == 2'(g))),
      .dec      (addr_dec[g]),
      .autoinit (autoinit[g]),
      .wr_addr  (wr_ch && (reg_addr[2:1] == 2'(g)) && !reg_addr[0]),
      .wr_cnt   (wr_ch && (reg_addr[2:1] == 2'(g)) &&  reg_addr[0]),
      .wr_hi    (byte_ptr),
      .wr_data  (db_in),
      .st       (st[g]),
      .tc_hit   (tc_hit[g])
    );
  end

  always_comb begin
    rd_data = 8'h00;
    rd_word = reg_addr[0] ? st[reg_addr[2:1]].cur_cnt : st[reg_addr[2:1]].cur_addr;
    if (ch_reg)
      rd_data = byte_ptr ? rd_word[15:8] : rd_word[7:0];
    else if (reg_addr == REG_STATUS)
      rd_data = {4'b0000, tc_status};
  end

  // Any change of channel restarts the MARK cadence.
  assign step_cnt_nxt = ((active_ch != last_ch) ? 16'h0000 : step_cnt) + {15'b0, xfer_step};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_ptr  <= 1'b0;
      db_out    <= '0;
      mem_addr  <= '0;
      tc        <= 1'b0;
      tc_status <= '0;
      mark      <= 1'b0;
      last_ch   <= '0;
      step_cnt  <= '0;
    end else if (mclr) begin
      byte_ptr  <= 1'b0;
      db_out    <= '0;
      mem_addr  <= '0;
      tc        <= 1'b0;
      tc_status <= '0;
      mark      <= 1'b0;
      last_ch   <= '0;
      step_cnt  <= '0;
    end else begin
      if (ptr_clr)      byte_ptr <= 1'b0;
      else if (ptr_tog) byte_ptr <= ~byte_ptr;
      if (rd_eff) db_out <= rd_data;
      // A TC landing on the same cycle as a status read survives the clear.
      tc_status <= (rd_status ? '0 : tc_status) | tc_hit;
      tc        <= |tc_hit;
      mem_addr  <= st[active_ch].cur_addr;
      last_ch   <= active_ch;
      step_cnt  <= step_cnt_nxt;
      mark      <= xfer_step && ((step_cnt_nxt & MARK_MASK) == 16'h0000);
    end
  end

endmodule

// File: tb/tb_dma_addr_count_unit.sv
module tb_dma_addr_count_unit;

  localparam int MARK_PERIOD = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_stb = 1'b0, rd_stb = 1'b0, xfer_step = 1'b0;
  logic [3:0] reg_addr = '0;
  logic [7:0] db_in = '0;
  logic [1:0] active_ch = '0;
  logic [3:0] autoinit = '0, addr_dec = '0;
  logic [7:0] db_out;
  logic [15:0] mem_addr;
  logic       tc, mark;
  logic [3:0] tc_status;

  int checks = 0;
  int errors = 0;

  dma_addr_count_unit #(.MARK_PERIOD(MARK_PERIOD)) dut (
    .clk(clk), .rst(rst), .wr_stb(wr_stb), .rd_stb(rd_stb), .reg_addr(reg_addr),
    .db_in(db_in), .db_out(db_out), .active_ch(active_ch), .xfer_step(xfer_step),
    .autoinit(autoinit), .addr_dec(addr_dec), .mem_addr(mem_addr), .tc(tc),
    .tc_status(tc_status), .mark(mark)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ba[4], m_ca[4], m_bc[4], m_cc[4];
  int m_ptr, m_ts, m_sc, m_last, m_db, m_mem, m_tc, m_mark;

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_ba[i] = 0; m_ca[i] = 0; m_bc[i] = 0; m_cc[i] = 0;
    end
    m_ptr = 0; m_ts = 0; m_sc = 0; m_last = 0;
    m_db = 0; m_mem = 0; m_tc = 0; m_mark = 0;
  endtask

  function automatic int put_byte(int v, int sh, int d);
    return (v & ~(255 << sh)) | (d << sh);
  endfunction

  task automatic m_clock();
    int ch, ra, wc, sh, word, na, nc, sa, set_bit, d;
    bit wr, rd, wr_a, wr_c;
    wr = wr_stb; rd = rd_stb && !wr_stb;
    ra = int'(reg_addr); d = int'(db_in);
    if (wr && ra == 13) begin m_reset(); return; end
    ch = int'(active_ch); wc = (ra >> 1) & 3; sh = m_ptr ? 8 : 0;
    m_mem = m_ca[ch]; m_tc = 0; m_mark = 0; set_bit = 0;
    if (rd) begin
      if (ra < 8) begin
        word = (ra & 1) ? m_cc[wc] : m_ca[wc];
        m_db = (word >> sh) & 255;
      end else if (ra == 8) m_db = m_ts;
      else m_db = 0;
    end
    wr_a = wr && ra < 8 && (ra & 1) == 0;
    wr_c = wr && ra < 8 && (ra & 1) == 1;
    if (xfer_step) begin
      sa = addr_dec[ch] ? (m_ca[ch] + 65535) % 65536 : (m_ca[ch] + 1) % 65536;
      if (m_cc[ch] == 0) begin
        m_tc = 1; set_bit = 1 << ch;
        if (autoinit[ch]) begin na = m_ba[ch]; nc = m_bc[ch]; end
        else begin na = sa; nc = 65535; end
      end else begin
        na = sa; nc = m_cc[ch] - 1;
      end
      if (!(wr_a && wc == ch)) m_ca[ch] = na;
      if (!(wr_c && wc == ch)) m_cc[ch] = nc;
    end
    if (ch != m_last) m_sc = 0;
    if (xfer_step) begin
      m_sc = (m_sc + 1) % 65536;
      m_mark = (m_sc % MARK_PERIOD == 0) ? 1 : 0;
    end
    m_last = ch;
    if (wr_a) begin m_ba[wc] = put_byte(m_ba[wc], sh, d); m_ca[wc] = put_byte(m_ca[wc], sh, d); end
    if (wr_c) begin m_bc[wc] = put_byte(m_bc[wc], sh, d); m_cc[wc] = put_byte(m_cc[wc], sh, d); end
    if (wr && ra == 12) m_ptr = 0;
    else if ((wr_stb || rd_stb) && ra < 8) m_ptr ^= 1;
    m_ts = ((rd && ra == 8) ? 0 : m_ts) | set_bit;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset(); else m_clock();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("db_out",    int'(db_out),    m_db);
        chk("mem_addr",  int'(mem_addr),  m_mem);
        chk("tc",        int'(tc),        m_tc);
        chk("tc_status", int'(tc_status), m_ts);
        chk("mark",      int'(mark),      m_mark);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(bit w, bit r, int a, int d, bit s);
    @(posedge clk); #1;
    wr_stb = w; rd_stb = r; reg_addr = 4'(a); db_in = 8'(d); xfer_step = s;
  endtask

  task automatic wr(int a, int d); cyc(1, 0, a, d, 0); endtask
  task automatic idle(); cyc(0, 0, 0, 0, 0); endtask

  task automatic rd(int a, output int d);
    cyc(0, 1, a, 0, 0); idle(); d = int'(db_out);
  endtask

  initial begin
    int v, marks, tcs, op;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle();
    chk("rst_db_out", int'(db_out), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_tc_status", int'(tc_status), 0);

    // ch1 basic transfer, TC on third step
    active_ch = 2'd1;
    wr(2, 8'h34); wr(2, 8'h12); wr(3, 8'h02); wr(3, 8'h00);
    idle();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1); chk("ch1_mem_s1", int'(mem_addr), 16'h1234);
    cyc(0, 0, 0, 0, 1); chk("ch1_mem_s2", int'(mem_addr), 16'h1235);
    idle();             chk("ch1_mem_s3", int'(mem_addr), 16'h1236);
    chk("ch1_tc", int'(tc), 1);
    chk("ch1_tc_status", int'(tc_status), 4'b0010);
    chk("mdl_ch1_cnt", m_cc[1], 16'hFFFF);

    // ch1 with autoinit: reload after TC
    autoinit = 4'b0010;
    wr(12, 0); wr(2, 8'h34); wr(2, 8'h12); wr(3, 8'h02); wr(3, 8'h00);
    repeat (3) cyc(0, 0, 0, 0, 1);
    idle();
    chk("ai_tc", int'(tc), 1);
    wr(12, 0);
    rd(2, v); chk("ai_addr_lo", v, 8'h34);
    rd(2, v); chk("ai_addr_hi", v, 8'h12);
    rd(3, v); chk("ai_cnt_lo", v, 8'h02);
    rd(3, v); chk("ai_cnt_hi", v, 8'h00);
    rd(8, v); chk("status_read", v, 8'h02);
    rd(8, v); chk("status_cleared", v, 8'h00);

    // ch0 decrement wraps 0000 -> FFFF
    wr(13, 0); idle();
    autoinit = 4'b0000; addr_dec = 4'b0001; active_ch = 2'd0;
    wr(0, 0); wr(0, 0); wr(1, 8'h05); wr(1, 8'h00);
    cyc(0, 0, 0, 0, 1); idle(); idle();
    chk("dec_mem_addr", int'(mem_addr), 16'hFFFF);
    wr(12, 0);
    rd(1, v); chk("dec_cnt_lo", v, 8'h04);
    rd(1, v); chk("dec_cnt_hi", v, 8'h00);

    // byte pointer clear
    wr(13, 0); addr_dec = 4'b0000;
    wr(0, 8'h55); wr(12, 0); wr(0, 8'hAA); wr(12, 0);
    rd(0, v); chk("ptr_lo", v, 8'hAA);
    rd(0, v); chk("ptr_hi", v, 8'h00);
    idle(); chk("ptr_mem_addr", int'(mem_addr), 16'h00AA);

    // ch2: 128 steps -> exactly one MARK, no TC
    wr(13, 0); active_ch = 2'd2;
    wr(12, 0); wr(5, 8'hFF); wr(5, 8'h00); idle();
    marks = 0; tcs = 0;
    for (int i = 0; i < 128; i++) begin
      cyc(0, 0, 0, 0, 1);
      marks += int'(mark); tcs += int'(tc);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      marks += int'(mark); tcs += int'(tc);
    end
    chk("mark_count", marks, 1);
    chk("mark_no_tc", tcs, 0);
    chk("mdl_ch2_cnt", m_cc[2], 127);

    // ch3 reset mid-transfer
    wr(13, 0); active_ch = 2'd3;
    wr(12, 0); wr(6, 8'h80); wr(6, 8'h01); wr(7, 8'h05); wr(7, 8'h00);
    cyc(0, 0, 0, 0, 1); idle();
    wr(12, 0);
    rd(6, v); chk("ch3_addr_lo", v, 8'h81);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_db_out", int'(db_out), 0);
    chk("rst_mid_mem", int'(mem_addr), 0);
    chk("rst_mid_tc", int'(tc), 0);
    chk("rst_mid_status", int'(tc_status), 0);
    chk("rst_mid_mark", int'(mark), 0);
    rst = 1'b0;
    idle();
    cyc(0, 0, 0, 0, 1); idle(); idle();
    chk("rst_ch3_mem", int'(mem_addr), 16'h0001);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 7) == 0) active_ch = 2'($urandom);
      if ($urandom_range(0, 31) == 0) autoinit = 4'($urandom);
      if ($urandom_range(0, 31) == 0) addr_dec = 4'($urandom);
      op = $urandom_range(0, 15);
      wr_stb = 1'b0; rd_stb = 1'b0;
      if (op < 4) begin
        wr_stb = 1'b1;
        v = $urandom_range(0, 19);
        reg_addr = (v < 14) ? 4'(v % 8) : (v < 17) ? 4'd12 : (v < 19) ? 4'(9 + v % 3) : 4'd13;
        if ($urandom_range(0, 199) != 0 && reg_addr == 4'd13) reg_addr = 4'd12;
      end else if (op < 7) begin
        rd_stb = 1'b1;
        v = $urandom_range(0, 11);
        reg_addr = (v < 8) ? 4'(v) : (v < 10) ? 4'd8 : 4'(14 + v % 2);
      end
      db_in = $urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      xfer_step = $urandom_range(0, 1) == 1;
    end
    rst = 1'b0;
    idle(); idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
